// File: rtl/mux21_2b_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux21_2b_arbiter_pkg
// Description : Shared definitions for the 2-bit 2:1 mux round-robin arbiter:
//               grant-state encoding, default burst length and the mux helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mux21_2b_arbiter_pkg;

  // Default number of consecutive beats one requester may take while the
  // other is waiting.
  localparam int unsigned c_default_max_burst = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  // The shared 2-bit 2:1 mux: sel=0 picks a, sel=1 picks b.
  function automatic logic [1:0] f_mux2(input logic       s,
                                        input logic [1:0] a,
                                        input logic [1:0] b);
    return s ? b : a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux21_out_stage.sv
`default_nettype none
// ============================================================================
// Module      : mux21_out_stage
// Description : Single-entry 2-bit valid/ready output register. Loads a new
//               word, holds it while the consumer stalls, drains on accept.
// Ports       : clk, reset_L     - clock, async active-low reset
//               i_load, i_data   - load strobe and word (only when o_can_load)
//               i_out_ready      - consumer accepts o_out_data this cycle
//               o_out_valid      - o_out_data holds a valid word
//               o_out_data       - registered word
//               o_can_load       - stage is empty or draining this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mux21_out_stage (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       i_load,
  input  logic [1:0] i_data,
  input  logic       i_out_ready,
  output logic       o_out_valid,
  output logic [1:0] o_out_data,
  output logic       o_can_load
);

  logic       r_valid;
  logic [1:0] r_data;

  // A new word may enter when the slot is empty or its occupant leaves now.
  assign o_can_load  = ~r_valid | i_out_ready;
  assign o_out_valid = r_valid;
  assign o_out_data  = r_data;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_valid <= 1'b0;
      r_data  <= 2'b00;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux21_2b_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux21_2b_arbiter
// Description : Round-robin arbiter sharing a 2-bit 2:1 mux between two
//               valid/ready requesters, with bursts of up to MAX_BURST beats
//               and one registered, backpressured output stage.
// Ports       : clk, reset_L                  - clock, async active-low reset
//               in0_valid/in0_data/in0_ready  - requester 0 handshake
//               in1_valid/in1_data/in1_ready  - requester 1 handshake
//               out_valid/out_data/out_ready  - consumer handshake
//               sel                           - mux select (1 only in GNT1)
// Revision    : 1.0 - initial release
// ============================================================================
module mux21_2b_arbiter
  import mux21_2b_arbiter_pkg::*;
#(
  parameter int MAX_BURST = c_default_max_burst,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       in0_valid,
  input  logic [1:0] in0_data,
  output logic       in0_ready,
  input  logic       in1_valid,
  input  logic [1:0] in1_data,
  output logic       in1_ready,
  output logic       out_valid,
  output logic [1:0] out_data,
  input  logic       out_ready,
  output logic       sel
);

  localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_BURST);

  arb_state_e       r_state,    w_state_nxt;
  logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic             r_last,     w_last_nxt;

  logic             w_can_load;
  logic             w_sel;
  logic             w_xfer;
  logic [1:0]       w_mux_data;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_burst_done;
  logic             w_own_valid;
  logic             w_other_valid;
  arb_state_e       w_other_st;

  // Select follows the registered grant, so it only moves on a clock edge.
  assign w_sel     = (r_state == ST_GNT1);
  assign sel       = w_sel;
  assign in0_ready = (r_state == ST_GNT0) & w_can_load;
  assign in1_ready = (r_state == ST_GNT1) & w_can_load;
  assign w_xfer    = (in0_valid & in0_ready) | (in1_valid & in1_ready);

  assign w_mux_data = f_mux2(w_sel, in0_data, in1_data);

  // Views of the current grantee and its competitor; only meaningful in GNTx.
  assign w_own_valid   = w_sel ? in1_valid : in0_valid;
  assign w_other_valid = w_sel ? in0_valid : in1_valid;
  assign w_other_st    = w_sel ? ST_GNT0 : ST_GNT1;

  assign w_cnt_inc    = r_beat_cnt + 1'b1;
  assign w_burst_done = (w_cnt_inc == c_max_cnt);

  mux21_out_stage u_out_stage (
    .clk         (clk),
    .reset_L     (reset_L),
    .i_load      (w_xfer),
    .i_data      (w_mux_data),
    .i_out_ready (out_ready),
    .o_out_valid (out_valid),
    .o_out_data  (out_data),
    .o_can_load  (w_can_load)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
      r_last     <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_last     <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_last_nxt     = r_last;
    case (r_state)
      ST_IDLE: begin
        // Ties go to whoever was not served last.
        if (in0_valid && in1_valid) begin
          w_state_nxt = r_last ? ST_GNT0 : ST_GNT1;
        end else if (in0_valid) begin
          w_state_nxt = ST_GNT0;
        end else if (in1_valid) begin
          w_state_nxt = ST_GNT1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (w_xfer) begin
          w_last_nxt = w_sel;
          if (w_burst_done) begin
            // Burst spent: hand over if the other side waits, otherwise
            // start a fresh burst for the same requester.
            w_beat_cnt_nxt = '0;
            if (w_other_valid) begin
              w_state_nxt = w_other_st;
            end
          end else begin
            w_beat_cnt_nxt = w_cnt_inc;
          end
        end else if (!w_own_valid) begin
          w_beat_cnt_nxt = '0;
          w_state_nxt    = w_other_valid ? w_other_st : ST_IDLE;
        end
        // Otherwise stalled with a pending word: hold state and count.
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_beat_cnt_nxt = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mux21_2b_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux21_2b_arbiter
// Description : Self-checking bench for mux21_2b_arbiter: vector table,
//               directed tie/fairness/reset/drop-out sequences and a random
//               phase scored against a queue-based model of the arbiter rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux21_2b_arbiter;

  localparam int MAX_BURST = 4;
  localparam int N_WORDS   = 150;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       in0_valid, in1_valid, out_ready;
  logic [1:0] in0_data, in1_data;
  logic       in0_ready, in1_ready, out_valid, sel;
  logic [1:0] out_data;

  always #5 clk = ~clk;

  mux21_2b_arbiter #(.MAX_BURST(MAX_BURST), .CNT_W(3)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       v0;
    logic [1:0] d0;
    logic       v1;
    logic [1:0] d1;
    logic       ordy;
    logic       e_ov;
    logic [1:0] e_od;
    logic       e_sel;
    logic       e_r0;
    logic       e_r1;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic v0, input logic [1:0] d0, input logic v1,
                              input logic [1:0] d1, input logic ordy, input logic e_ov,
                              input logic [1:0] e_od, input logic e_sel,
                              input logic e_r0, input logic e_r1);
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.ordy = ordy;
    v.e_ov = e_ov; v.e_od = e_od; v.e_sel = e_sel; v.e_r0 = e_r0; v.e_r1 = e_r1;
    return v;
  endfunction

  task automatic drive(input logic v0, input logic [1:0] d0, input logic v1,
                       input logic [1:0] d1, input logic ordy);
    in0_valid = v0; in0_data = d0; in1_valid = v1; in1_data = d1; out_ready = ordy;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset sel", sel, 0);
    reset_L = 1'b1;
  endtask

  // Step one cycle: new inputs just after the edge, observe at mid-cycle.
  task automatic step(input logic v0, input logic [1:0] d0, input logic v1,
                      input logic [1:0] d1, input logic ordy);
    @(posedge clk);
    #1;
    drive(v0, d0, v1, d1, ordy);
    @(negedge clk);
  endtask

  // ---------------- random-phase model ----------------
  logic [1:0] q0[$], q1[$], exp_q[$];
  logic       hs0 = 1'b0, hs1 = 1'b0;
  bit         rand_mode = 1'b0;
  int         streak0 = 0, streak1 = 0, n_delivered = 0;

  // Rules: one output slot in acceptance order, never both readies, and a
  // continuously waiting requester sees at most MAX_BURST beats of the other.
  always @(negedge clk) begin
    if (rand_mode) begin
      check("rand both_ready", in0_ready & in1_ready, 0);
      check("rand out_valid", out_valid, (exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) check("rand out_data", out_data, exp_q[0]);
      hs0 = in0_valid & in0_ready;
      hs1 = in1_valid & in1_ready;
      if (!in1_valid || hs1) streak0 = 0;
      else if (hs0) begin
        streak0++;
        check("rand burst0_limit", (streak0 > MAX_BURST), 0);
      end
      if (!in0_valid || hs0) streak1 = 0;
      else if (hs1) begin
        streak1++;
        check("rand burst1_limit", (streak1 > MAX_BURST), 0);
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        n_delivered++;
      end
      if (hs0) exp_q.push_back(in0_data);
      if (hs1) exp_q.push_back(in1_data);
    end
  end

  initial begin
    // Single source, backpressure with 11 held, burst wrap, handover, drain.
    vecs[0]  = mk(1'b1, 2'd1, 1'b0, 2'd0, 1'b1,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 2'd1, 1'b0, 2'd0, 1'b1,  1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    vecs[2]  = mk(1'b1, 2'd2, 1'b0, 2'd0, 1'b1,  1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
    vecs[3]  = mk(1'b1, 2'd3, 1'b0, 2'd0, 1'b1,  1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
    vecs[4]  = mk(1'b1, 2'd0, 1'b0, 2'd0, 1'b0,  1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(1'b1, 2'd0, 1'b0, 2'd0, 1'b0,  1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 2'd0, 1'b0, 2'd0, 1'b0,  1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mk(1'b1, 2'd0, 1'b0, 2'd0, 1'b1,  1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
    vecs[8]  = mk(1'b0, 2'd0, 1'b1, 2'd2, 1'b1,  1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
    vecs[9]  = mk(1'b0, 2'd0, 1'b1, 2'd2, 1'b1,  1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    vecs[10] = mk(1'b0, 2'd0, 1'b0, 2'd0, 1'b1,  1'b1, 2'd2, 1'b1, 1'b0, 1'b1);
    vecs[11] = mk(1'b0, 2'd0, 1'b0, 2'd0, 1'b1,  1'b0, 2'd2, 1'b0, 1'b0, 1'b0);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].ordy);
      check($sformatf("vec%0d out_valid", i), out_valid, vecs[i].e_ov);
      check($sformatf("vec%0d out_data", i), out_data, vecs[i].e_od);
      check($sformatf("vec%0d sel", i), sel, vecs[i].e_sel);
      check($sformatf("vec%0d in0_ready", i), in0_ready, vecs[i].e_r0);
      check($sformatf("vec%0d in1_ready", i), in1_ready, vecs[i].e_r1);
    end

    // Tie from IDLE after reset, then fairness 01x4, 10x4, 01x4.
    do_reset();
    step(1'b1, 2'b01, 1'b1, 2'b10, 1'b1);
    check("tie idle in0_ready", in0_ready, 0);
    check("tie idle in1_ready", in1_ready, 0);
    for (int k = 0; k <= 12; k++) begin
      step(1'b1, 2'b01, 1'b1, 2'b10, 1'b1);
      check($sformatf("fair sel k%0d", k), sel, (k / 4) % 2);
      if (k >= 1) begin
        check($sformatf("fair out_valid k%0d", k), out_valid, 1);
        check($sformatf("fair out_data k%0d", k), out_data,
              (((k - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10);
      end
    end

    // Asynchronous reset in the middle of a burst.
    @(posedge clk);
    #3;
    reset_L = 1'b0;
    #1;
    check("async reset out_valid", out_valid, 0);
    check("async reset out_data", out_data, 0);
    check("async reset sel", sel, 0);
    check("async reset in0_ready", in0_ready, 0);
    drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
    @(negedge clk);
    reset_L = 1'b1;

    // Drop-out: in1 leaves after 2 beats while in0 waits.
    do_reset();
    step(1'b0, 2'd0, 1'b1, 2'b01, 1'b1);
    check("drop idle sel", sel, 0);
    check("drop idle in1_ready", in1_ready, 0);
    step(1'b1, 2'b11, 1'b1, 2'b01, 1'b1);
    check("drop gnt1 sel", sel, 1);
    check("drop gnt1 in1_ready", in1_ready, 1);
    step(1'b1, 2'b11, 1'b1, 2'b10, 1'b1);
    check("drop beat2 out_data", out_data, 2'b01);
    step(1'b1, 2'b11, 1'b0, 2'b00, 1'b1);
    check("drop release sel", sel, 1);
    check("drop release out_data", out_data, 2'b10);
    step(1'b1, 2'b11, 1'b0, 2'b00, 1'b1);
    check("drop switch sel", sel, 0);
    check("drop switch in0_ready", in0_ready, 1);
    check("drop switch in1_ready", in1_ready, 0);
    step(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
    check("drop last out_valid", out_valid, 1);
    check("drop last out_data", out_data, 2'b11);
    step(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
    check("drop drained out_valid", out_valid, 0);
    check("drop idle in0_ready", in0_ready, 0);

    // Random traffic against the queue model.
    do_reset();
    for (int i = 0; i < N_WORDS; i++) begin
      q0.push_back(2'($urandom_range(0, 3)));
      q1.push_back(2'($urandom_range(0, 3)));
    end
    @(posedge clk);
    #1;
    hs0 = 1'b0;
    hs1 = 1'b0;
    rand_mode = 1'b1;
    begin
      int cyc;
      cyc = 0;
      while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0) && cyc < 4000) begin
        if (hs0) begin
          void'(q0.pop_front());
          in0_valid = 1'b0;
        end
        if (hs1) begin
          void'(q1.pop_front());
          in1_valid = 1'b0;
        end
        if (!in0_valid && q0.size() != 0 && $urandom_range(0, 99) < 70) begin
          in0_valid = 1'b1;
          in0_data  = q0[0];
        end
        if (!in1_valid && q1.size() != 0 && $urandom_range(0, 99) < 70) begin
          in1_valid = 1'b1;
          in1_data  = q1[0];
        end
        out_ready = ($urandom_range(0, 99) < 70);
        @(posedge clk);
        #1;
        cyc++;
      end
      check("rand drain_timeout", (cyc >= 4000), 0);
    end
    rand_mode = 1'b0;
    check("rand words_delivered", n_delivered, 2 * N_WORDS);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
